// File: rtl/fpu_iterative_shift_engine_if.sv
// Handshake and data bundle between the FPU operand/exponent logic and the
// iterative mantissa shift engine.
interface fpu_iterative_shift_engine_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] data_in;
    logic [CNT_W-1:0] shift_req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_out;
    logic [CNT_W-1:0] shift_count;
    logic             sticky;
    logic             zero;

    modport master (
        output start, mode, data_in, shift_req,
        input  busy, done, data_out, shift_count, sticky, zero
    );

    modport slave (
        input  start, mode, data_in, shift_req,
        output busy, done, data_out, shift_count, sticky, zero
    );
endinterface

// File: rtl/fpu_iterative_shift_engine.sv
// Multi-cycle mantissa shifter: align (right shift with sticky) or normalize
// (left shift until the MSB is set), at most STEP_MAX bits per cycle.
module fpu_iterative_shift_engine #(
    parameter int WIDTH    = 64,
    parameter int CNT_W    = 7,
    parameter int STEP_MAX = 7
) (
    input  logic clk,
    input  logic reset_n,
    fpu_iterative_shift_engine_if.slave bus
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             acc_sticky_q, acc_sticky_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0] count_out_q, count_out_d;
    logic             sticky_out_q, sticky_out_d;
    logic             zero_out_q, zero_out_d;

    logic [2:0]       step_s;
    logic [WIDTH-1:0] mask_s;
    logic [WIDTH-1:0] shifted_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W-1:0] rem_next_s;
    logic             sticky_next_s;

    // Leading zeros of the top seven bits; all-zero saturates at the 7-bit step.
    function automatic logic [2:0] lead_zeros7(input logic [6:0] top);
        logic [2:0] n;
        n = 3'd7;
        for (int i = 0; i < 7; i++) begin
            n = top[i] ? 3'(6 - i) : n;
        end
        return n;
    endfunction

    // Next-state, datapath step and result publication.
    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        remain_d      = remain_q;
        mode_d        = mode_q;
        acc_cnt_d     = acc_cnt_q;
        acc_sticky_d  = acc_sticky_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        data_out_d    = data_out_q;
        count_out_d   = count_out_q;
        sticky_out_d  = sticky_out_q;
        zero_out_d    = zero_out_q;
        step_s        = 3'd0;
        mask_s        = {WIDTH{1'b0}};
        shifted_s     = work_q;
        cnt_next_s    = acc_cnt_q;
        rem_next_s    = remain_q;
        sticky_next_s = acc_sticky_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    work_d       = bus.data_in;
                    mode_d       = bus.mode;
                    remain_d     = bus.shift_req;
                    acc_cnt_d    = {CNT_W{1'b0}};
                    acc_sticky_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!mode_q) begin
                    // Amounts of a full width or more flush everything into sticky in one cycle.
                    if (remain_q >= CNT_W'(WIDTH)) begin
                        state_d      = ST_IDLE;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        data_out_d   = {WIDTH{1'b0}};
                        count_out_d  = remain_q;
                        sticky_out_d = |work_q;
                        zero_out_d   = 1'b0;
                    end else begin
                        step_s        = (remain_q > CNT_W'(STEP_MAX)) ? 3'(STEP_MAX) : remain_q[2:0];
                        mask_s        = (WIDTH'(1) << step_s) - WIDTH'(1);
                        shifted_s     = work_q >> step_s;
                        sticky_next_s = acc_sticky_q | (|(work_q & mask_s));
                        cnt_next_s    = acc_cnt_q + CNT_W'(step_s);
                        rem_next_s    = remain_q - CNT_W'(step_s);
                        work_d        = shifted_s;
                        acc_cnt_d     = cnt_next_s;
                        acc_sticky_d  = sticky_next_s;
                        remain_d      = rem_next_s;
                        if (rem_next_s == {CNT_W{1'b0}}) begin
                            state_d      = ST_IDLE;
                            busy_d       = 1'b0;
                            done_d       = 1'b1;
                            data_out_d   = shifted_s;
                            count_out_d  = cnt_next_s;
                            sticky_out_d = sticky_next_s;
                            zero_out_d   = 1'b0;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end
                end else begin
                    // A non-zero operand never loses set bits on a left step, so zero is only seen up front.
                    if (work_q == {WIDTH{1'b0}}) begin
                        state_d      = ST_IDLE;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        data_out_d   = {WIDTH{1'b0}};
                        count_out_d  = {CNT_W{1'b0}};
                        sticky_out_d = 1'b0;
                        zero_out_d   = 1'b1;
                    end else begin
                        step_s     = lead_zeros7(work_q[WIDTH-1 -: 7]);
                        shifted_s  = work_q << step_s;
                        cnt_next_s = acc_cnt_q + CNT_W'(step_s);
                        work_d     = shifted_s;
                        acc_cnt_d  = cnt_next_s;
                        if (shifted_s[WIDTH-1]) begin
                            state_d      = ST_IDLE;
                            busy_d       = 1'b0;
                            done_d       = 1'b1;
                            data_out_d   = shifted_s;
                            count_out_d  = cnt_next_s;
                            sticky_out_d = 1'b0;
                            zero_out_d   = 1'b0;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            work_q       <= {WIDTH{1'b0}};
            remain_q     <= {CNT_W{1'b0}};
            mode_q       <= 1'b0;
            acc_cnt_q    <= {CNT_W{1'b0}};
            acc_sticky_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            data_out_q   <= {WIDTH{1'b0}};
            count_out_q  <= {CNT_W{1'b0}};
            sticky_out_q <= 1'b0;
            zero_out_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            remain_q     <= remain_d;
            mode_q       <= mode_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_sticky_q <= acc_sticky_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            data_out_q   <= data_out_d;
            count_out_q  <= count_out_d;
            sticky_out_q <= sticky_out_d;
            zero_out_q   <= zero_out_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.data_out    = data_out_q;
    assign bus.shift_count = count_out_q;
    assign bus.sticky      = sticky_out_q;
    assign bus.zero        = zero_out_q;
endmodule

// File: tb/tb_fpu_iterative_shift_engine.sv
// Scoreboard bench for the iterative shift engine: directed operations push
// hand-computed results; a done-driven monitor pops and compares them.
module tb_fpu_iterative_shift_engine;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   cyc;

    typedef struct {
        logic [63:0] data;
        logic [6:0]  cnt;
        logic        st;
        logic        z;
        int          lat;
        int          e0;
    } exp_t;

    exp_t sb[$];

    fpu_iterative_shift_engine_if bus_if ();

    fpu_iterative_shift_engine dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus_if.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data_out",    bus_if.data_out,           e.data);
                check("shift_count", 64'(bus_if.shift_count),   64'(e.cnt));
                check("sticky",      64'(bus_if.sticky),        64'(e.st));
                check("zero",        64'(bus_if.zero),          64'(e.z));
                check("latency",     64'(cyc - e.e0),           64'(e.lat));
                check("busy_at_done", 64'(bus_if.busy),         64'd0);
            end
        end
    end

    task automatic push_exp(input logic [63:0] d, input logic [6:0] c, input logic s,
                            input logic z, input int lat);
        exp_t e;
        e.data = d; e.cnt = c; e.st = s; e.z = z; e.lat = lat; e.e0 = cyc + 1;
        sb.push_back(e);
    endtask

    // Drives start for exactly one edge (E0); returns at the negedge after E0.
    task automatic start_op(input logic m, input logic [63:0] d, input logic [6:0] req);
        bus_if.start     = 1'b1;
        bus_if.mode      = m;
        bus_if.data_in   = d;
        bus_if.shift_req = req;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic op(input logic m, input logic [63:0] d, input logic [6:0] req,
                      input logic [63:0] ed, input logic [6:0] ec, input logic es,
                      input logic ez, input int lat);
        @(negedge clk);
        push_exp(ed, ec, es, ez, lat);
        start_op(m, d, req);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for done, outstanding=%0d", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset_n          = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.mode      = 1'b0;
        bus_if.data_in   = 64'd0;
        bus_if.shift_req = 7'd0;
        repeat (3) @(negedge clk);
        check("rst_busy",   64'(bus_if.busy),        64'd0);
        check("rst_done",   64'(bus_if.done),        64'd0);
        check("rst_data",   bus_if.data_out,         64'd0);
        check("rst_count",  64'(bus_if.shift_count), 64'd0);
        check("rst_sticky", 64'(bus_if.sticky),      64'd0);
        check("rst_zero",   64'(bus_if.zero),        64'd0);
        reset_n = 1'b1;

        // Align by 10: steps 7 then 3.
        op(1'b0, 64'h8000_0000_0000_0001, 7'd10, 64'h0020_0000_0000_0000, 7'd10, 1'b1, 1'b0, 2);
        check("align10_busy_e1", 64'(bus_if.busy), 64'd1);
        drain("align10");

        // Normalize of 1: 63 leading zeros over nine steps.
        op(1'b1, 64'h0000_0000_0000_0001, 7'd0, 64'h8000_0000_0000_0000, 7'd63, 1'b0, 1'b0, 9);
        drain("norm1");
        repeat (3) @(negedge clk);
        check("hold_data",  bus_if.data_out,         64'h8000_0000_0000_0000);
        check("hold_count", 64'(bus_if.shift_count), 64'd63);

        op(1'b1, 64'h0, 7'd5, 64'h0, 7'd0, 1'b0, 1'b1, 1);
        drain("norm_zero");
        op(1'b1, 64'h8000_0000_0000_0000, 7'd0, 64'h8000_0000_0000_0000, 7'd0, 1'b0, 1'b0, 1);
        drain("norm_msb");
        op(1'b1, 64'h0000_0000_0000_0100, 7'd0, 64'h8000_0000_0000_0000, 7'd55, 1'b0, 1'b0, 8);
        drain("norm_bit8");
        op(1'b0, 64'h0000_0000_0000_00FF, 7'd70, 64'h0, 7'd70, 1'b1, 1'b0, 1);
        drain("align70");
        op(1'b0, 64'h8000_0000_0000_0000, 7'd64, 64'h0, 7'd64, 1'b1, 1'b0, 1);
        drain("align64");
        op(1'b0, 64'h8000_0000_0000_0000, 7'd63, 64'h0000_0000_0000_0001, 7'd63, 1'b0, 1'b0, 9);
        drain("align63");
        op(1'b0, 64'h1234_5678_9ABC_DEF0, 7'd0, 64'h1234_5678_9ABC_DEF0, 7'd0, 1'b0, 1'b0, 1);
        drain("align0");
        op(1'b0, 64'h0000_0000_0000_0180, 7'd7, 64'h0000_0000_0000_0003, 7'd7, 1'b0, 1'b0, 1);
        drain("align7");

        // Start held into E1 with new operand must be ignored while busy.
        @(negedge clk);
        push_exp(64'h0000_0000_0000_0001, 7'd21, 1'b0, 1'b0, 3);
        bus_if.start     = 1'b1;
        bus_if.mode      = 1'b0;
        bus_if.data_in   = 64'h0000_0000_0020_0000;
        bus_if.shift_req = 7'd21;
        @(negedge clk);
        bus_if.data_in   = 64'hFFFF_FFFF_FFFF_FFFF;
        bus_if.shift_req = 7'd5;
        @(negedge clk);
        bus_if.start = 1'b0;
        drain("ignored_start");
        repeat (5) @(negedge clk);

        // Reset at E4 of a normalize aborts with no done.
        @(negedge clk);
        start_op(1'b1, 64'h0000_0000_0000_0001, 7'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_busy",   64'(bus_if.busy),        64'd0);
        check("abort_done",   64'(bus_if.done),        64'd0);
        check("abort_data",   bus_if.data_out,         64'd0);
        check("abort_count",  64'(bus_if.shift_count), 64'd0);
        check("abort_sticky", 64'(bus_if.sticky),      64'd0);
        check("abort_zero",   64'(bus_if.zero),        64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        op(1'b0, 64'h0000_0000_0000_00FF, 7'd8, 64'h0, 7'd8, 1'b1, 1'b0, 2);
        drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
